// File: rtl/ls_pkg.sv
// Shared definitions for the load/store decode path: opcodes, funct3 codes,
// the 4-bit lane type encoding and instruction field positions.
package ls_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int OPC_LSB      = 0;
    localparam int RD_LSB       = 7;
    localparam int F3_LSB       = 12;
    localparam int RS1_LSB      = 15;
    localparam int RS2_LSB      = 20;
    localparam int IMM_I_LSB    = 20;
    localparam int IMM_S_HI_LSB = 25;
    localparam int IMM_S_LO_LSB = 7;

    localparam int REG_W  = 5;
    localparam int IMM_W  = 12;
    localparam int TYPE_W = 4;

    // Bit 3 flags an unsigned load; 0111 is reserved for "not a load/store".
    typedef enum logic [TYPE_W-1:0] {
        LS_LW   = 4'b0000,
        LS_LH   = 4'b0001,
        LS_LB   = 4'b0010,
        LS_SW   = 4'b0100,
        LS_SH   = 4'b0101,
        LS_SB   = 4'b0110,
        LS_NONE = 4'b0111,
        LS_LHU  = 4'b1001,
        LS_LBU  = 4'b1010
    } ls_type_t;

    function automatic logic is_store_type(ls_type_t t);
        return (t == LS_SW) || (t == LS_SH) || (t == LS_SB);
    endfunction

endpackage

// File: rtl/ls_lane_decode.sv
// Combinational decode of one lane: classifies a load/store and pulls out
// its register fields and 12-bit immediate; everything else decodes as LS_NONE.
module ls_lane_decode
    import ls_pkg::*;
#(
    parameter int INS_WIDTH = 32
) (
    input  logic [INS_WIDTH-1:0] ins_i,
    input  logic                 valid_i,
    output logic                 ls_valid_o,
    output ls_type_t             type_o,
    output logic [IMM_W-1:0]     imm_o,
    output logic [REG_W-1:0]     rs1_o,
    output logic [REG_W-1:0]     rs2_o,
    output logic [REG_W-1:0]     rd_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    ls_type_t   lane_type;

    assign opcode = ins_i[OPC_LSB +: 7];
    assign funct3 = ins_i[F3_LSB +: 3];

    // funct7 is deliberately not part of the key.
    always_comb begin
        lane_type = LS_NONE;
        if (valid_i && (opcode == OPC_LOAD)) begin
            case (funct3)
                F3_B:    lane_type = LS_LB;
                F3_H:    lane_type = LS_LH;
                F3_W:    lane_type = LS_LW;
                F3_BU:   lane_type = LS_LBU;
                F3_HU:   lane_type = LS_LHU;
                default: lane_type = LS_NONE;
            endcase
        end else if (valid_i && (opcode == OPC_STORE)) begin
            case (funct3)
                F3_B:    lane_type = LS_SB;
                F3_H:    lane_type = LS_SH;
                F3_W:    lane_type = LS_SW;
                default: lane_type = LS_NONE;
            endcase
        end
    end

    always_comb begin
        ls_valid_o = 1'b0;
        type_o     = lane_type;
        imm_o      = '0;
        rs1_o      = '0;
        rs2_o      = '0;
        rd_o       = '0;
        if (lane_type != LS_NONE) begin
            ls_valid_o = 1'b1;
            rs1_o      = ins_i[RS1_LSB +: REG_W];
            if (is_store_type(lane_type)) begin
                imm_o = {ins_i[IMM_S_HI_LSB +: 7], ins_i[IMM_S_LO_LSB +: 5]};
                rs2_o = ins_i[RS2_LSB +: REG_W];
            end else begin
                imm_o = ins_i[IMM_I_LSB +: IMM_W];
                rd_o  = ins_i[RD_LSB +: REG_W];
            end
        end
    end

endmodule

// File: rtl/ls_decode_stage.sv
// N-lane load/store decode stage: per-lane decode, LSQ tag allocation,
// credit-gated acceptance and a single valid/ready output register.
module ls_decode_stage
    import ls_pkg::*;
#(
    parameter int INS_WIDTH = 32,
    parameter int ISSUE_W   = 2,
    parameter int LSQ_DEPTH = 8,
    parameter int TAG_W     = $clog2(LSQ_DEPTH),
    parameter int CNT_W     = $clog2(LSQ_DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [ISSUE_W-1:0]           ins_valid_i,
    input  logic [ISSUE_W*INS_WIDTH-1:0] ins_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ISSUE_W-1:0]           ls_valid_o,
    output logic [ISSUE_W*TYPE_W-1:0]    ls_type_o,
    output logic [ISSUE_W*IMM_W-1:0]     ls_imm_o,
    output logic [ISSUE_W*REG_W-1:0]     ls_rs1_o,
    output logic [ISSUE_W*REG_W-1:0]     ls_rs2_o,
    output logic [ISSUE_W*REG_W-1:0]     ls_rd_o,
    output logic [ISSUE_W*TAG_W-1:0]     ls_tag_o,
    input  logic [CNT_W-1:0]             lsq_free_i
);

    localparam int                   SUM_W       = CNT_W + 1;
    localparam logic [CNT_W-1:0]     CREDIT_MAX  = CNT_W'(LSQ_DEPTH);
    localparam logic [TYPE_W-1:0]    NONE_BITS   = LS_NONE;
    localparam logic [ISSUE_W*TYPE_W-1:0] TYPE_IDLE = {ISSUE_W{NONE_BITS}};

    // Per-lane decode results
    logic [ISSUE_W-1:0]           dec_valid;
    logic [ISSUE_W*TYPE_W-1:0]    dec_type;
    logic [ISSUE_W*IMM_W-1:0]     dec_imm;
    logic [ISSUE_W*REG_W-1:0]     dec_rs1;
    logic [ISSUE_W*REG_W-1:0]     dec_rs2;
    logic [ISSUE_W*REG_W-1:0]     dec_rd;
    logic [ISSUE_W*TAG_W-1:0]     dec_tag;
    ls_type_t                     lane_type [ISSUE_W];
    logic [CNT_W-1:0]             ls_before [ISSUE_W+1];

    // Registered state
    logic                         out_valid_q, out_valid_d;
    logic [ISSUE_W-1:0]           valid_q, valid_d;
    logic [ISSUE_W*TYPE_W-1:0]    type_q, type_d;
    logic [ISSUE_W*IMM_W-1:0]     imm_q, imm_d;
    logic [ISSUE_W*REG_W-1:0]     rs1_q, rs1_d;
    logic [ISSUE_W*REG_W-1:0]     rs2_q, rs2_d;
    logic [ISSUE_W*REG_W-1:0]     rd_q, rd_d;
    logic [ISSUE_W*TAG_W-1:0]     tag_q, tag_d;
    logic [TAG_W-1:0]             tag_ptr_q, tag_ptr_d;
    logic [CNT_W-1:0]             credit_q, credit_d;

    logic                         in_ready;
    logic                         accept;
    logic [CNT_W-1:0]             n_ls;
    logic [SUM_W-1:0]             credit_sum;

    assign ls_before[0] = '0;

    // ls_before[k] counts LS lanes below lane k, giving each lane its tag offset.
    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_lane
            ls_lane_decode #(
                .INS_WIDTH (INS_WIDTH)
            ) u_dec (
                .ins_i      (ins_i[gi*INS_WIDTH +: INS_WIDTH]),
                .valid_i    (ins_valid_i[gi]),
                .ls_valid_o (dec_valid[gi]),
                .type_o     (lane_type[gi]),
                .imm_o      (dec_imm[gi*IMM_W +: IMM_W]),
                .rs1_o      (dec_rs1[gi*REG_W +: REG_W]),
                .rs2_o      (dec_rs2[gi*REG_W +: REG_W]),
                .rd_o       (dec_rd[gi*REG_W +: REG_W])
            );

            assign dec_type[gi*TYPE_W +: TYPE_W] = lane_type[gi];
            assign ls_before[gi+1] = ls_before[gi] + CNT_W'(dec_valid[gi]);
            assign dec_tag[gi*TAG_W +: TAG_W] =
                dec_valid[gi] ? (tag_ptr_q + ls_before[gi][TAG_W-1:0]) : '0;
        end
    endgenerate

    assign n_ls = ls_before[ISSUE_W];

    // Credit check assumes a full bundle so readiness never looks at the instructions.
    assign in_ready = (!out_valid_q || out_ready_i)
                    && (credit_q >= CNT_W'(ISSUE_W))
                    && !flush_i;
    assign accept   = in_ready && (|ins_valid_i);

    assign credit_sum = {1'b0, credit_q}
                      - (accept ? {1'b0, n_ls} : '0)
                      + {1'b0, lsq_free_i};

    always_comb begin
        out_valid_d = out_valid_q;
        valid_d     = valid_q;
        type_d      = type_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        tag_d       = tag_q;
        tag_ptr_d   = tag_ptr_q;
        credit_d    = credit_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
            valid_d     = '0;
            type_d      = TYPE_IDLE;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            tag_d       = '0;
            tag_ptr_d   = '0;
            credit_d    = CREDIT_MAX;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                valid_d     = dec_valid;
                type_d      = dec_type;
                imm_d       = dec_imm;
                rs1_d       = dec_rs1;
                rs2_d       = dec_rs2;
                rd_d        = dec_rd;
                tag_d       = dec_tag;
                tag_ptr_d   = tag_ptr_q + n_ls[TAG_W-1:0];
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
                valid_d     = '0;
                type_d      = TYPE_IDLE;
                imm_d       = '0;
                rs1_d       = '0;
                rs2_d       = '0;
                rd_d        = '0;
                tag_d       = '0;
            end
            // Over-return of credits is illegal; clamp rather than wrap.
            if (credit_sum > SUM_W'(LSQ_DEPTH)) begin
                credit_d = CREDIT_MAX;
            end else begin
                credit_d = credit_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            valid_q     <= '0;
            type_q      <= TYPE_IDLE;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            tag_q       <= '0;
            tag_ptr_q   <= '0;
            credit_q    <= CREDIT_MAX;
        end else begin
            out_valid_q <= out_valid_d;
            valid_q     <= valid_d;
            type_q      <= type_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            tag_q       <= tag_d;
            tag_ptr_q   <= tag_ptr_d;
            credit_q    <= credit_d;
        end
    end

    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        credit_sum <= SUM_W'(LSQ_DEPTH));

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign ls_valid_o  = valid_q;
    assign ls_type_o   = type_q;
    assign ls_imm_o    = imm_q;
    assign ls_rs1_o    = rs1_q;
    assign ls_rs2_o    = rs2_q;
    assign ls_rd_o     = rd_q;
    assign ls_tag_o    = tag_q;

endmodule

// File: tb/tb_ls_decode_stage.sv
// Bench for ls_decode_stage: directed vector table, hand-written corner
// sequences, then random traffic against a queue-free behavioural model.
module tb_ls_decode_stage;

    localparam int INS_W = 32;
    localparam int IW    = 2;
    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int CNT_W = 4;

    localparam logic [31:0] I_LW  = 32'h00812283; // lw  x5, 8(x2)
    localparam logic [31:0] I_SW  = 32'h0061A623; // sw  x6, 12(x3)
    localparam logic [31:0] I_LBU = 32'h0040C383; // lbu x7, 4(x1)
    localparam logic [31:0] I_LHU = 32'hFFE25483; // lhu x9, -2(x4)
    localparam logic [31:0] I_ADD = 32'h003100B3; // add x1, x2, x3

    logic                  clk;
    logic                  rst_ni;
    logic                  flush_i;
    logic [IW-1:0]         ins_valid;
    logic [IW*INS_W-1:0]   ins;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW-1:0]         ls_valid;
    logic [IW*4-1:0]       ls_type;
    logic [IW*12-1:0]      ls_imm;
    logic [IW*5-1:0]       ls_rs1;
    logic [IW*5-1:0]       ls_rs2;
    logic [IW*5-1:0]       ls_rd;
    logic [IW*TAG_W-1:0]   ls_tag;
    logic [CNT_W-1:0]      lsq_free;

    ls_decode_stage #(
        .INS_WIDTH (INS_W),
        .ISSUE_W   (IW),
        .LSQ_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .ins_valid_i (ins_valid),
        .ins_i       (ins),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .ls_valid_o  (ls_valid),
        .ls_type_o   (ls_type),
        .ls_imm_o    (ls_imm),
        .ls_rs1_o    (ls_rs1),
        .ls_rs2_o    (ls_rs2),
        .ls_rd_o     (ls_rd),
        .ls_tag_o    (ls_tag),
        .lsq_free_i  (lsq_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    bit m_init = 0;
    bit m_valid;
    int m_credit, m_ptr;
    int m_lsv[IW], m_type[IW], m_imm[IW], m_rs1[IW], m_rs2[IW], m_rd[IW], m_tag[IW];

    // Type code by funct3 for each opcode class; 7 = not a load/store
    int load_code[8]  = '{2, 1, 0, 7, 10, 9, 7, 7};
    int store_code[8] = '{6, 5, 4, 7, 7, 7, 7, 7};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [31:0] w, input bit v,
                              output int lsv, output int typ, output int imm,
                              output int rs1, output int rs2, output int rd);
        int opc, f3;
        opc = int'(w[6:0]);
        f3  = int'(w[14:12]);
        typ = 7;
        if (v && opc == 3)       typ = load_code[f3];
        else if (v && opc == 35) typ = store_code[f3];
        lsv = (typ != 7) ? 1 : 0;
        imm = 0; rs1 = 0; rs2 = 0; rd = 0;
        if (lsv == 1) begin
            rs1 = int'(w[19:15]);
            if (opc == 35) begin
                imm = int'(w[31:25]) * 32 + int'(w[11:7]);
                rs2 = int'(w[24:20]);
            end else begin
                imm = int'(w[31:20]);
                rd  = int'(w[11:7]);
            end
        end
    endtask

    task automatic clear_lanes();
        for (int j = 0; j < IW; j++) begin
            m_lsv[j] = 0; m_type[j] = 7; m_imm[j] = 0;
            m_rs1[j] = 0; m_rs2[j] = 0; m_rd[j] = 0; m_tag[j] = 0;
        end
    endtask

    function automatic bit model_ready();
        return (!m_valid || out_ready) && (m_credit >= IW) && !flush_i;
    endfunction

    // Advance the model by one clock using the inputs held across that edge.
    task automatic model_step();
        bit rdy;
        int n;
        rdy = model_ready();
        n = 0;
        if (!rst_ni) begin
            m_init = 1; m_valid = 0; clear_lanes(); m_credit = DEPTH; m_ptr = 0;
        end else if (flush_i) begin
            m_valid = 0; clear_lanes(); m_credit = DEPTH; m_ptr = 0;
        end else begin
            if (rdy && ins_valid != '0) begin
                for (int j = 0; j < IW; j++) begin
                    ref_decode(ins[j*INS_W +: INS_W], ins_valid[j], m_lsv[j], m_type[j],
                               m_imm[j], m_rs1[j], m_rs2[j], m_rd[j]);
                    m_tag[j] = 0;
                    if (m_lsv[j] == 1) begin
                        m_tag[j] = (m_ptr + n) % DEPTH;
                        n++;
                    end
                end
                m_ptr = (m_ptr + n) % DEPTH;
                m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0; clear_lanes();
            end
            m_credit = m_credit - n + int'(lsq_free);
            if (m_credit > DEPTH) m_credit = DEPTH;
        end
    endtask

    task automatic compare_outputs();
        logic [IW-1:0]       e_lsv;
        logic [IW*4-1:0]     e_type;
        logic [IW*12-1:0]    e_imm;
        logic [IW*5-1:0]     e_rs1, e_rs2, e_rd;
        logic [IW*TAG_W-1:0] e_tag;
        for (int j = 0; j < IW; j++) begin
            e_lsv[j]               = m_lsv[j][0];
            e_type[j*4 +: 4]       = 4'(m_type[j]);
            e_imm[j*12 +: 12]      = 12'(m_imm[j]);
            e_rs1[j*5 +: 5]        = 5'(m_rs1[j]);
            e_rs2[j*5 +: 5]        = 5'(m_rs2[j]);
            e_rd[j*5 +: 5]         = 5'(m_rd[j]);
            e_tag[j*TAG_W +: TAG_W] = TAG_W'(m_tag[j]);
        end
        chk("out_valid", out_valid, m_valid);
        chk("ls_valid", ls_valid, e_lsv);
        chk("ls_type", ls_type, e_type);
        chk("ls_imm", ls_imm, e_imm);
        chk("ls_rs1", ls_rs1, e_rs1);
        chk("ls_rs2", ls_rs2, e_rs2);
        chk("ls_rd", ls_rd, e_rd);
        chk("ls_tag", ls_tag, e_tag);
    endtask

    // One clock: check readiness mid-cycle, then the registered outputs after the edge.
    task automatic cycle();
        @(negedge clk);
        if (m_init) chk("in_ready", in_ready, model_ready());
        @(posedge clk);
        #1;
        model_step();
        if (m_init) compare_outputs();
    endtask

    task automatic drive(input logic [31:0] l1, input logic [31:0] l0,
                         input logic [1:0] v, input int free);
        ins       = {l1, l0};
        ins_valid = v;
        lsq_free  = CNT_W'(free);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 9);
        if (k < 4)      r[6:0] = 7'b0000011;
        else if (k < 7) r[6:0] = 7'b0100011;
        else if (k < 8) r[6:0] = 7'b0110011;
        return r;
    endfunction

    typedef struct packed {
        logic [31:0] ins1;
        logic [31:0] ins0;
        logic [1:0]  v;
        logic [1:0]  lsv;
        logic [7:0]  typ;
        logic [23:0] imm;
        logic [9:0]  rs1;
        logic [9:0]  rs2;
        logic [9:0]  rd;
        logic [5:0]  tag;
    } vec_t;

    vec_t tbl[3];

    initial begin
        logic [IW*4-1:0]     snap_type;
        logic [IW*12-1:0]    snap_imm;
        logic [IW*TAG_W-1:0] snap_tag;
        int lim;

        tbl[0] = '{ins1: I_SW,  ins0: I_LW,  v: 2'b11, lsv: 2'b11, typ: 8'h40,
                   imm: 24'h00C008, rs1: 10'h062, rs2: 10'h0C0, rd: 10'h005, tag: 6'h08};
        tbl[1] = '{ins1: I_ADD, ins0: I_LBU, v: 2'b11, lsv: 2'b01, typ: 8'h7A,
                   imm: 24'h000004, rs1: 10'h001, rs2: 10'h000, rd: 10'h007, tag: 6'h02};
        tbl[2] = '{ins1: I_ADD, ins0: I_LHU, v: 2'b11, lsv: 2'b01, typ: 8'h79,
                   imm: 24'h000FFE, rs1: 10'h004, rs2: 10'h000, rd: 10'h009, tag: 6'h03};

        rst_ni = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
        drive(32'h0, 32'h0, 2'b00, 0);
        cycle();
        cycle();
        rst_ni = 1'b1;
        #1;
        chk("ready_after_reset", in_ready, 1'b1);
        chk("reset_types", ls_type, 8'h77);
        cycle();

        // Directed decode vectors (lw/sw, lbu+add, lhu+add), one bundle per cycle
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i].ins1, tbl[i].ins0, tbl[i].v, 0);
            cycle();
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_lsv", ls_valid, tbl[i].lsv);
            chk("tbl_type", ls_type, tbl[i].typ);
            chk("tbl_imm", ls_imm, tbl[i].imm);
            chk("tbl_rs1", ls_rs1, tbl[i].rs1);
            chk("tbl_rs2", ls_rs2, tbl[i].rs2);
            chk("tbl_rd", ls_rd, tbl[i].rd);
            chk("tbl_tag", ls_tag, tbl[i].tag);
        end

        // Tag wrap: walk P from 4 to 7 with single-LS bundles, then two LS lanes
        for (int i = 0; i < 3; i++) begin
            drive(I_ADD, I_LW, 2'b01, 1);
            cycle();
        end
        drive(I_SW, I_LW, 2'b11, 2);
        cycle();
        chk("wrap_tags", ls_tag, 6'h07);

        // Credit drain to 1, then refill by one, then simultaneous alloc/free
        drive(I_SW, I_LW, 2'b11, 0);
        cycle();
        drive(I_ADD, I_LW, 2'b01, 0);
        cycle();
        drive(I_SW, I_LW, 2'b00, 0);
        #1;
        chk("ready_credit1", in_ready, 1'b0);
        cycle();
        drive(I_SW, I_LW, 2'b00, 1);
        cycle();
        drive(I_SW, I_LW, 2'b00, 0);
        #1;
        chk("ready_credit2", in_ready, 1'b1);
        drive(I_SW, I_LW, 2'b11, 2);
        cycle();
        drive(I_SW, I_LW, 2'b00, 0);
        #1;
        chk("ready_balanced", in_ready, 1'b1);
        cycle();

        // Output stall for three cycles, then release with next bundle waiting
        drive(I_SW, I_LW, 2'b00, 2);
        cycle();
        drive(I_SW, I_LW, 2'b11, 0);
        cycle();
        snap_type = ls_type; snap_imm = ls_imm; snap_tag = ls_tag;
        out_ready = 1'b0;
        drive(I_SW, I_LHU, 2'b11, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", in_ready, 1'b0);
            cycle();
            chk("stall_type", ls_type, snap_type);
            chk("stall_imm", ls_imm, snap_imm);
            chk("stall_tag", ls_tag, snap_tag);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", in_ready, 1'b1);
        cycle();
        chk("release_type", ls_type, 8'h49);
        chk("release_tag", ls_tag, 6'h08);

        // Flush during a stall
        out_ready = 1'b0;
        flush_i = 1'b1;
        drive(I_SW, I_LW, 2'b11, 0);
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_type", ls_type, 8'h77);
        flush_i = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_credit_ready", in_ready, 1'b1);
        cycle();
        chk("flush_tags", ls_tag, 6'h08);

        // Reset mid-stream while stalled
        out_ready = 1'b0;
        drive(I_SW, I_LBU, 2'b11, 0);
        cycle();
        rst_ni = 1'b0;
        cycle();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_type", ls_type, 8'h77);
        rst_ni = 1'b1;
        out_ready = 1'b1;
        drive(I_SW, I_LW, 2'b00, 0);
        #1;
        chk("rst_ready", in_ready, 1'b1);
        drive(I_SW, I_LW, 2'b11, 0);
        cycle();
        chk("rst_tags", ls_tag, 6'h08);

        // Random traffic with legal credit returns
        for (int c = 0; c < 1500; c++) begin
            rst_ni    = ($urandom_range(0, 199) != 0);
            flush_i   = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ins_valid = 2'($urandom_range(0, 3));
            ins       = {rand_ins(), rand_ins()};
            lim = DEPTH - m_credit;
            if (lim > IW) lim = IW;
            lsq_free = CNT_W'($urandom_range(0, lim));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
